// File: rtl/alu_pkg.sv
// Shared definitions for the ALU issue front-end: opcode encodings and the
// issue FSM state type.
package alu_pkg;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_2   = 3'b010;
  localparam logic [2:0] OP_3   = 3'b011;
  localparam logic [2:0] OP_4   = 3'b100;
  localparam logic [2:0] OP_MAX = 3'b100;

  typedef enum logic [1:0] {
    IDLE,
    EXEC,
    DONE
  } state_t;

endpackage

// File: rtl/alu_issue_alu.sv
// Combinational ALU datapath: add, subtract, and, or, xor.
// Overflow reports signed two's-complement overflow for add/sub only.
module ALU
  import alu_pkg::*;
#(
  parameter int N = 32
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic [2:0]   op,
  output logic [N-1:0] c,
  output logic         ov
);

  // Select the operation result and derive signed overflow from the sign bits.
  always_comb begin
    c  = '0;
    ov = 1'b0;
    case (op)
      OP_ADD: begin
        c  = a + b;
        ov = (a[N-1] == b[N-1]) && (c[N-1] != a[N-1]);
      end
      OP_SUB: begin
        c  = a - b;
        ov = (a[N-1] != b[N-1]) && (c[N-1] != a[N-1]);
      end
      OP_2:    c = a & b;
      OP_3:    c = a | b;
      OP_4:    c = a ^ b;
      default: c = '0;
    endcase
  end

endmodule

// File: rtl/alu_issue.sv
// Sequential issue front-end for the ALU: one operation in flight, request
// and response valid/ready handshakes, completed-operation counter.
// Optional feature macro: ALU_ISSUE_STICKY_OV_EN adds a sticky overflow flag.
module alu_issue
  import alu_pkg::*;
#(
  parameter int N     = 32,
  parameter int TAG_W = 4,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [N-1:0]     req_a,
  input  logic [N-1:0]     req_b,
  input  logic [2:0]       req_op,
  input  logic [TAG_W-1:0] req_tag,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [N-1:0]     rsp_c,
  output logic             rsp_ov,
  output logic             rsp_err,
  output logic [TAG_W-1:0] rsp_tag,
  output logic [CNT_W-1:0] op_count,
  output logic             ov_sticky
);

  state_t           state;
  logic [N-1:0]     a_q;
  logic [N-1:0]     b_q;
  logic [2:0]       op_q;
  logic [TAG_W-1:0] tag_q;
  logic [N-1:0]     alu_c;
  logic             alu_ov;
  logic             rsp_fire;

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  ALU #(.N(N)) u_alu (
    .a  (a_q),
    .b  (b_q),
    .op (op_q),
    .c  (alu_c),
    .ov (alu_ov)
  );

  // Ready depends only on state and flush; held low while reset is asserted.
  assign req_ready = rst_n && (state == IDLE) && !flush;
  assign rsp_valid = (state == DONE);
  assign rsp_fire  = (state == DONE) && rsp_ready && !flush;

  // Issue FSM: capture request, evaluate once, hold response until consumed.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      a_q      <= '0;
      b_q      <= '0;
      op_q     <= OP_ADD;
      tag_q    <= '0;
      rsp_c    <= '0;
      rsp_ov   <= 1'b0;
      rsp_err  <= 1'b0;
      rsp_tag  <= '0;
      op_count <= '0;
    end else if (flush) begin
      state <= IDLE;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            a_q   <= req_a;
            b_q   <= req_b;
            op_q  <= req_op;
            tag_q <= req_tag;
            state <= EXEC;
          end
        end
        EXEC: begin
          if (op_q > OP_MAX) begin
            rsp_c   <= '0;
            rsp_ov  <= 1'b0;
            rsp_err <= 1'b1;
          end else begin
            rsp_c   <= alu_c;
            rsp_ov  <= alu_ov;
            rsp_err <= 1'b0;
          end
          rsp_tag <= tag_q;
          state   <= DONE;
        end
        DONE: begin
          if (rsp_ready) begin
            op_count <= op_count + CNT_ONE;
            state    <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef ALU_ISSUE_STICKY_OV_EN
  // Sticky overflow: set by any consumed overflowing response, cleared by flush.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ov_sticky <= 1'b0;
    end else if (flush) begin
      ov_sticky <= 1'b0;
    end else if (rsp_fire && rsp_ov) begin
      ov_sticky <= 1'b1;
    end
  end
`else
  assign ov_sticky = 1'b0;
`endif

endmodule
